uart_rx_fifo: RTL and testbench

UART receiver for the ibex system's `RX` pin: it recovers 8N1 frames with 16x oversampling and queues the received bytes in a show-ahead FIFO. A bus-side reader pops bytes through a valid/ready handshake. The block runs entirely on `clk_sys` and is the receive counterpart of the system UART transmitter on `TX`.

---
 rtl/uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO
//
// Parameters:
//   OVS_DIV    - clk_sys cycles per 1/16 bit (2..65535)
//   FIFO_DEPTH - FIFO entries, power of 2, >= 2
// Ports:
//   clk_sys    - system clock
//   rst_sys_n  - asynchronous active-low reset
//   RX         - serial line, idle high, asynchronous
//   rd_data    - head-of-FIFO byte, meaningful while rd_valid
//   rd_valid   - FIFO not empty
//   rd_ready   - pop request, pop on rd_valid && rd_ready
//   fifo_count - number of stored bytes
//   frame_err  - sticky, stop bit sampled low
//   overrun    - sticky, byte dropped on full FIFO
//   clr_err    - pulse clearing both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int OVS_DIV    = 68,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_sys,
    input  logic                          rst_sys_n,
    input  logic                          RX,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] PS_MAX   = 16'(OVS_DIV - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [15:0] r_prescale;
    logic [3:0]  r_tick;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_push;
    logic [7:0]  r_push_data;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_tick;
    logic        w_start_det;
    logic        w_clr_ticks;
    logic        w_data_smp;
    logic        w_stop_ok;
    logic        w_stop_bad;
    logic        w_pop;
    logic        w_full;
    logic        w_wr_en;
    logic        w_drop;
    logic [AW:0] w_count;

    assign w_tick = (r_prescale == PS_MAX);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_det = 1'b0;
        w_clr_ticks = 1'b0;
        w_data_smp  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a held-low break never retriggers.
                if (r_rx_prev && !r_rx_s) begin
                    w_start_det = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick && (r_tick == 4'd7)) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_clr_ticks = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_tick && (r_tick == 4'd15)) begin
                    w_data_smp = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_tick && (r_tick == 4'd15)) begin
                    w_stop_ok   = r_rx_s;
                    w_stop_bad  = !r_rx_s;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_prescale  <= 16'd0;
            r_tick      <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_push      <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;

            // Restarting the prescaler on the start edge aligns the sample points to the edge.
            if (w_start_det || w_tick) begin
                r_prescale <= 16'd0;
            end else begin
                r_prescale <= r_prescale + 16'd1;
            end

            if (w_start_det || w_clr_ticks) begin
                r_tick <= 4'd0;
            end else if (w_tick && (r_state != S_IDLE)) begin
                r_tick <= r_tick + 4'd1;
            end

            if (w_clr_ticks) begin
                r_bit_idx <= 3'd0;
            end else if (w_data_smp) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_data_smp) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end

            r_push      <= w_stop_ok;
            r_push_data <= r_shift;
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_pop   = rd_valid && rd_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
    assign w_wr_en = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign rd_valid   = (w_count != '0);
    assign fifo_count = w_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;
    localparam int OVS   = 4;
    localparam int DEPTH = 8;
    localparam int BIT   = 16 * OVS;
    // Pin fall -> start seen (3) -> stop sample (152 ticks) -> push cycle -> visible (+1)
    localparam int LAT_FERR = 3 + 152 * OVS;
    localparam int LAT_PUSH = LAT_FERR + 1;

    logic       clk_sys;
    logic       rst_sys_n;
    logic       RX;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    uart_rx_fifo #(
        .OVS_DIV    (OVS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .RX         (RX),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t        ev[$];
    logic [7:0] mq[$];
    bit         m_ferr;
    bit         m_ovr;
    int         cyc = 0;
    bit         run_cmp = 0;
    int         m_sz;
    bit         m_popped;
    bit         m_set_f;
    bit         m_set_o;

    // Reference model: frames mature at a fixed latency after their pin fall; the queue is the FIFO.
    always @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            mq.delete();
            ev.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            cyc++;
            m_sz     = mq.size();
            m_popped = rd_ready && (m_sz > 0);
            m_set_f  = 1'b0;
            m_set_o  = 1'b0;
            if (m_popped) begin
                void'(mq.pop_front());
            end
            for (int i = ev.size() - 1; i >= 0; i--) begin
                if (ev[i].due == cyc) begin
                    if (!ev[i].ok) begin
                        m_set_f = 1'b1;
                    end else if ((m_sz == DEPTH) && !m_popped) begin
                        m_set_o = 1'b1;
                    end else begin
                        mq.push_back(ev[i].data);
                    end
                    ev.delete(i);
                end
            end
            m_ferr = m_set_f ? 1'b1 : (clr_err ? 1'b0 : m_ferr);
            m_ovr  = m_set_o ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
        end
    end

    always @(negedge clk_sys) begin
        if (run_cmp) begin
            check("cmp_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
            check("cmp_fifo_count", 32'(fifo_count), 32'(mq.size()));
            if (mq.size() != 0) begin
                check("cmp_rd_data", 32'(rd_data), 32'(mq[0]));
            end
            check("cmp_frame_err", 32'(frame_err), 32'(m_ferr));
            check("cmp_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit pop_at_push, output int vld_at);
        logic [9:0] bits;
        int         n;
        bits   = {stop_bit, data, 1'b0};
        vld_at = -1;
        @(posedge clk_sys);
        #1;
        n = cyc;
        ev.push_back('{(stop_bit ? n + LAT_PUSH : n + LAT_FERR), data, bit'(stop_bit)});
        for (int c = 0; c < 10 * BIT; c++) begin
            if (c > 0) begin
                @(posedge clk_sys);
                #1;
            end
            RX = bits[c / BIT];
            if (pop_at_push) begin
                rd_ready = (c == LAT_PUSH - 1);
            end
            if ((vld_at < 0) && rd_valid) begin
                vld_at = c;
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] data, input int ncyc);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk_sys);
            #1;
            RX = bits[c / BIT];
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        step(1);
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        step(1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        step(1);
    endtask

    int v;

    initial begin
        RX        = 1'b1;
        rd_ready  = 1'b0;
        clr_err   = 1'b0;
        rst_sys_n = 1'b0;
        step(3);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_sys_n = 1'b1;
        run_cmp   = 1'b1;
        step(5);

        // Single byte 0xA5
        send_frame(8'hA5, 1'b1, 1'b0, v);
        check("single_latency", 32'(v), 32'd612);
        check("single_within_bound", 32'(v >= 0 && v <= 10 * BIT + 4), 32'd1);
        check("single_data", 32'(rd_data), 32'hA5);
        check("single_count", 32'(fifo_count), 32'd1);
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        check("single_pop_valid", 32'(rd_valid), 32'd0);
        check("single_pop_count", 32'(fifo_count), 32'd0);
        rd_ready = 1'b1;
        step(2);
        rd_ready = 1'b0;
        check("empty_pop_count", 32'(fifo_count), 32'd0);

        // Glitch shorter than half a bit
        RX = 1'b0;
        step(20);
        RX = 1'b1;
        step(100);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        check("glitch_ovr", 32'(overrun), 32'd0);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0, v);
        step(2 * BIT);
        RX = 1'b1;
        step(2 * BIT);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);
        pulse_clr();
        check("ferr_clear", 32'(frame_err), 32'd0);

        // Overrun: nine bytes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, v);
        end
        step(2);
        check("ovr_count", 32'(fifo_count), 32'd8);
        check("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_expect("ovr_pop", 8'(i));
        end
        step(1);
        check("ovr_drained", 32'(rd_valid), 32'd0);
        pulse_clr();
        check("ovr_clear", 32'(overrun), 32'd0);

        // Full FIFO with a pop in the push cycle of the ninth byte
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1, 1'b0, v);
        end
        send_frame(8'h55, 1'b1, 1'b1, v);
        step(2);
        check("fullpop_ovr", 32'(overrun), 32'd0);
        check("fullpop_count", 32'(fifo_count), 32'd8);
        for (int i = 1; i < 8; i++) begin
            pop_expect("fullpop_pop", 8'h11 + 8'(i));
        end
        pop_expect("fullpop_last", 8'h55);
        step(1);
        check("fullpop_drained", 32'(rd_valid), 32'd0);

        // Reset during data bit 4
        send_frame(8'h99, 1'b1, 1'b0, v);
        check("prerst_count", 32'(fifo_count), 32'd1);
        send_partial(8'hC3, 5 * BIT + BIT / 2);
        rst_sys_n = 1'b0;
        RX        = 1'b1;
        #2;
        check("async_rst_valid", 32'(rd_valid), 32'd0);
        check("async_rst_count", 32'(fifo_count), 32'd0);
        check("async_rst_data", 32'(rd_data), 32'h00);
        step(3);
        rst_sys_n = 1'b1;
        step(10);
        check("postrst_valid", 32'(rd_valid), 32'd0);
        check("postrst_ferr", 32'(frame_err), 32'd0);
        check("postrst_ovr", 32'(overrun), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0, v);
        check("postrst_count", 32'(fifo_count), 32'd1);
        pop_expect("postrst_pop", 8'h7E);
        step(2);
        check("postrst_drained", 32'(rd_valid), 32'd0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
